serial_sub_using_hs: RTL and testbench
======================================

// Module: serial_sub_using_hs
// PURPOSE
//  Bit-serial N-bit subtractor: the subtract-direction counterpart of the adder path.
//  Captures operands a and b on start, then computes diff = a - b LSB-first, one bit per clock.
//  The datapath is a full subtractor built from two half subtractors plus an OR, feeding a borrow flip-flop.
//  Sits beside the adder blocks in the arithmetic library for area-constrained datapaths.
// PARAMETERS
//  WIDTH  8  operand/result width in bits, >= 2
// PORTS
//  clk     in   1      single clock, rising edge
//  rst     in   1      asynchronous, active-high reset
//  start   in   1      request; sampled only while busy=0
//  a       in   WIDTH  minuend, captured on the accepted start edge
//  b       in   WIDTH  subtrahend, captured on the accepted start edge
//  busy    out  1      high while bits are being processed
//  done    out  1      one-cycle pulse; diff/borrow valid from this cycle onward
//  diff    out  WIDTH  (a - b) mod 2^WIDTH, held until the next accepted start completes
//  borrow  out  1      final borrow: 1 iff a < b (unsigned), held like diff
//  d_bit   out  1      serial difference bit of the current shift cycle (LSB first)
//  d_vld   out  1      d_bit is valid this cycle (equals busy)
// BEHAVIOUR
//  Reset: rst=1 forces state IDLE, and these outputs/registers to 0: busy, done, diff, borrow,
//   d_bit, d_vld, count, and the shift registers. The reset acts immediately, mid-operation included.
//   A partial result is discarded; done is not pulsed for an aborted operation.
//  States:
//   IDLE -> SHIFT on start=1.
//   SHIFT -> DONE after WIDTH bits.
//   DONE -> IDLE on the next edge, or DONE -> SHIFT if start=1.
//  Accept: start is sampled when state is IDLE or DONE (busy=0).
//   On that edge: load sa<=a, sb<=b; clear the borrow FF and count.
//   start during SHIFT is ignored; it is not queued.
//  Per SHIFT edge, with bit ai=sa[0], bi=sb[0], and bin = borrow FF:
//   d  = ai ^ bi ^ bin
//   bo = (~ai & bi) | (~(ai ^ bi) & bin)
//   Shift sa and sb right; shift d into the MSB of the result register; borrow FF <= bo; count++.
//  Latency: the start edge is E0. Bits are processed on edges E0+1 .. E0+WIDTH.
//   done=1 during the cycle after edge E0+WIDTH, i.e. WIDTH+1 cycles after the start edge.
//  busy=1 from E0 through edge E0+WIDTH; busy=0 in DONE.
//  diff/borrow update only on the edge entering DONE. Between operations they hold the last result.
//  Back-to-back: start=1 in the DONE cycle begins a new operation with no idle gap.
//   done then lasts exactly one cycle.
//  Wrap-around: results are modulo 2^WIDTH; unsigned underflow is reported solely via borrow.
//  count width: clog2(WIDTH+1). count never exceeds WIDTH.
// STRUCTURE
//  Shared header arith_defs.vh: default WIDTH and the state encodings
//   (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2), so the adder and subtractor serial blocks agree.
//  Sub-module hs (half subtractor, combinational): d = x ^ y; bo = ~x & y.
//  Full subtractor: hs h1(ai, bi) -> (w1, w2); hs h2(w1, bin) -> (d, w3); bo = w2 | w3.
//  All other logic (FSM, counter, shift registers, borrow FF) lives in this module.
// TESTING (WIDTH=8 unless noted)
//  1. a=8'h05, b=8'h03, start pulse -> d_bit stream 0,1,0,0,0,0,0,0;
//     done at E0+9; diff=8'h02, borrow=0.
//  2. a=8'h03, b=8'h05 -> diff=8'hFE, borrow=1.
//     a=8'h00, b=8'h01 -> diff=8'hFF, borrow=1 (full borrow ripple).
//  3. a=8'hFF, b=8'hFF -> diff=8'h00, borrow=0.
//     a=8'h80, b=8'h00 -> diff=8'h80, borrow=0.
//  4. start held high through SHIFT with changing a/b -> result reflects only the operands captured at E0.
//     A second op starts from the DONE cycle; done pulses exactly one cycle each.
//  5. Assert rst at the 4th SHIFT cycle -> busy, done, diff, borrow all 0 immediately, with no done pulse.
//     After release, a=8'h10, b=8'h01 -> diff=8'h0F.
//  6. WIDTH=4, exhaustive 256 (a,b) pairs -> diff/borrow match a reference model {borrow,diff} = {1'b0,a} - {1'b0,b}.

Source files
------------

// File: rtl/serial_sub_using_hs_pkg.sv
// Shared definitions for the serial arithmetic blocks.
// Default width and state encodings agree with the serial adder.
package serial_sub_using_hs_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bits needed for a counter that runs 0..w inclusive.
    function automatic int cnt_bits(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/serial_sub_using_hs_hs.sv
// Half subtractor: difference and borrow-out of x - y.
// Two of these plus an OR form the full subtractor cell.
module hs (
    input  logic x,
    input  logic y,
    output logic d,
    output logic bo
);

    assign d  = x ^ y;
    assign bo = ~x & y;

endmodule

// File: rtl/serial_sub_using_hs.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one bit per clock.
// Full subtractor from two half subtractors feeding a borrow flop.
module serial_sub_using_hs
    import serial_sub_using_hs_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             d_bit,
    output logic             d_vld
);

    localparam int CW = cnt_bits(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    count;
    logic             bff;

    logic w1;
    logic w2;
    logic w3;
    logic d;
    logic bo;

    // Full subtractor on the current LSBs and the stored borrow.
    hs h1 (
        .x  (sa[0]),
        .y  (sb[0]),
        .d  (w1),
        .bo (w2)
    );

    hs h2 (
        .x  (w1),
        .y  (bff),
        .d  (d),
        .bo (w3)
    );

    assign bo = w2 | w3;

    // The bit being processed is visible only while shifting.
    assign d_bit = busy & d;
    assign d_vld = busy;

    // Control FSM, operand/result shifters, borrow flop and outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
            count  <= '0;
            sa     <= '0;
            sb     <= '0;
            res    <= '0;
            bff    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        res   <= '0;
                        bff   <= 1'b0;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    res   <= {d, res[WIDTH-1:1]};
                    bff   <= bo;
                    count <= count + CW'(1);
                    if (count == LAST) begin
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        diff   <= {d, res[WIDTH-1:1]};
                        borrow <= bo;
                        state  <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_using_hs.sv
// Directed bench for the serial subtractor.
// Covers WIDTH=8 scenarios and an exhaustive WIDTH=4 sweep.
module tb_serial_sub_using_hs;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow;
    logic       d_bit;
    logic       d_vld;

    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       busy4;
    logic       done4;
    logic [3:0] diff4;
    logic       borrow4;
    logic       d_bit4;
    logic       d_vld4;

    int tests;
    int fails;

    serial_sub_using_hs #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow),
        .d_bit  (d_bit),
        .d_vld  (d_vld)
    );

    serial_sub_using_hs #(.WIDTH(4)) dut4 (
        .clk    (clk),
        .rst    (rst),
        .start  (start4),
        .a      (a4),
        .b      (b4),
        .busy   (busy4),
        .done   (done4),
        .diff   (diff4),
        .borrow (borrow4),
        .d_bit  (d_bit4),
        .d_vld  (d_vld4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Run one WIDTH=8 op from idle; checks stream, done timing, result.
    task automatic op8(input string tag, input logic [7:0] ta,
                       input logic [7:0] tb_, input logic [7:0] exp_diff,
                       input logic exp_bo);
        logic [7:0] bits;
        logic [7:0] vld;
        @(negedge clk);
        a = ta;
        b = tb_;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bits[i] = d_bit;
            vld[i]  = d_vld & busy & ~done;
            @(negedge clk);
        end
        chk({tag, "_stream"}, {24'd0, bits}, {24'd0, exp_diff});
        chk({tag, "_vld"}, {24'd0, vld}, 32'h0000_00FF);
        chk({tag, "_done"}, {30'd0, done, busy}, 32'd2);
        chk({tag, "_res"}, {23'd0, borrow, diff}, {23'd0, exp_bo, exp_diff});
        @(negedge clk);
        chk({tag, "_pulse"}, {30'd0, done, busy}, 32'd0);
    endtask

    initial begin
        logic [4:0] ref5;
        tests  = 0;
        fails  = 0;
        rst    = 1'b1;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        start4 = 1'b0;
        a4     = '0;
        b4     = '0;
        repeat (2) @(negedge clk);
        chk("reset_outs", {26'd0, busy, done, borrow, d_bit, d_vld, 1'b0},
            32'd0);
        chk("reset_diff", {24'd0, diff}, 32'd0);
        rst = 1'b0;

        op8("t1_05_03", 8'h05, 8'h03, 8'h02, 1'b0);
        // Result is held across idle cycles.
        repeat (3) @(negedge clk);
        chk("t1_hold", {23'd0, borrow, diff}, {23'd0, 1'b0, 8'h02});

        op8("t2_03_05", 8'h03, 8'h05, 8'hFE, 1'b1);
        op8("t2_00_01", 8'h00, 8'h01, 8'hFF, 1'b1);
        op8("t3_FF_FF", 8'hFF, 8'hFF, 8'h00, 1'b0);
        op8("t3_80_00", 8'h80, 8'h00, 8'h80, 1'b0);

        // Start held high through SHIFT while operands wander.
        @(negedge clk);
        a = 8'h05;
        b = 8'h03;
        start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a = 8'($urandom);
            b = 8'($urandom);
            if (i == 0) chk("t4_busy", {31'd0, busy}, 32'd1);
        end
        @(negedge clk);
        chk("t4_done1", {30'd0, done, busy}, 32'd2);
        chk("t4_res1", {23'd0, borrow, diff}, {23'd0, 1'b0, 8'h02});
        a = 8'h20;
        b = 8'h01;
        @(negedge clk);
        chk("t4_b2b", {30'd0, done, busy}, 32'd1);
        start = 1'b0;
        a = 8'hFF;
        b = 8'h00;
        repeat (8) @(negedge clk);
        chk("t4_done2", {30'd0, done, busy}, 32'd2);
        chk("t4_res2", {23'd0, borrow, diff}, {23'd0, 1'b0, 8'h1F});
        @(negedge clk);
        chk("t4_pulse2", {30'd0, done, busy}, 32'd0);

        // Reset during the fourth shift cycle.
        a = 8'h55;
        b = 8'h11;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_pre", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("t5_rst", {21'd0, busy, done, borrow, d_vld, d_bit, 6'd0, diff},
            32'd0);
        @(negedge clk);
        rst = 1'b0;
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                seen = seen | done | busy;
            end
            chk("t5_nodone", {31'd0, seen}, 32'd0);
        end
        op8("t5_10_01", 8'h10, 8'h01, 8'h0F, 1'b0);

        // Exhaustive WIDTH=4 sweep against a reference subtraction.
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                @(negedge clk);
                a4 = 4'(i);
                b4 = 4'(j);
                start4 = 1'b1;
                @(negedge clk);
                start4 = 1'b0;
                repeat (4) @(negedge clk);
                ref5 = {1'b0, 4'(i)} - {1'b0, 4'(j)};
                chk($sformatf("t6_%0d_%0d", i, j),
                    {26'd0, done4, borrow4, diff4}, {26'd0, 1'b1, ref5});
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
